// File: rtl/spi_regfile_periph.sv
// spi_regfile_periph: SPI mode-0 target exposing a bank of read/write config registers
module spi_regfile_periph #(
  parameter int NUM_REGS    = 5,
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       sclk,
  input  logic                       copi,
  input  logic                       ncs,
  output logic                       cipo,
  output logic                       cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0] regs_flat,
  output logic                       wr_pulse,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic                       frame_err
);
  localparam int FRAME_W = 1 + ADDR_W + DATA_W;
  localparam int HDR_W   = 1 + ADDR_W;
  localparam int SH_W    = DATA_W > ADDR_W ? DATA_W : ADDR_W;
  localparam int CNT_W   = $clog2(FRAME_W + 2);
  localparam int S       = SYNC_STAGES;
  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;
  logic [S-1:0] sclk_q, copi_q, ncs_q, vld_q;
  state_t state_q, state_d;
  logic armed_q, armed_d;
  logic [SH_W-1:0] sh_q, sh_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [HDR_W-1:0] hdr_q, hdr_d;
  logic [DATA_W-1:0] tx_q, tx_d, rd_val;
  logic rd_q, rd_d, hit;
  logic [NUM_REGS*DATA_W-1:0] regs_q, regs_d;
  logic wr_pulse_q, wr_pulse_d, frame_err_q, frame_err_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic sclk_rise, sclk_fall, ncs_rise, ncs_fall, ncs_s, copi_s;
  assign sclk_rise = sclk_q[S-2] & ~sclk_q[S-1];
  assign sclk_fall = ~sclk_q[S-2] & sclk_q[S-1];
  assign ncs_rise  = ncs_q[S-2] & ~ncs_q[S-1];
  assign ncs_fall  = ~ncs_q[S-2] & ncs_q[S-1];
  assign ncs_s     = ncs_q[S-2];
  assign copi_s    = copi_q[S-1];
  // Synchronisers; vld_q marks when every stage holds a real pin sample rather than a reset value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_q <= '0;
      copi_q <= '0;
      ncs_q  <= '1;
      vld_q  <= '0;
    end else begin
      sclk_q <= {sclk_q[S-2:0], sclk};
      copi_q <= {copi_q[S-2:0], copi};
      ncs_q  <= {ncs_q[S-2:0], ncs};
      vld_q  <= {vld_q[S-2:0], 1'b1};
    end
  end
  // Frame FSM, shifters, register bank and strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      armed_q     <= 1'b0;
      sh_q        <= '0;
      cnt_q       <= '0;
      hdr_q       <= '0;
      tx_q        <= '0;
      rd_q        <= 1'b0;
      regs_q      <= '0;
      wr_pulse_q  <= 1'b0;
      wr_addr_q   <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      armed_q     <= armed_d;
      sh_q        <= sh_d;
      cnt_q       <= cnt_d;
      hdr_q       <= hdr_d;
      tx_q        <= tx_d;
      rd_q        <= rd_d;
      regs_q      <= regs_d;
      wr_pulse_q  <= wr_pulse_d;
      wr_addr_q   <= wr_addr_d;
      frame_err_q <= frame_err_d;
    end
  end
  // Next state: an ncs rise ends the frame and masks any sclk edge seen in the same cycle
  always_comb begin
    state_d     = state_q;
    armed_d     = armed_q | (vld_q[S-1] & ncs_s);
    sh_d        = sh_q;
    cnt_d       = cnt_q;
    hdr_d       = hdr_q;
    tx_d        = tx_q;
    rd_d        = rd_q;
    regs_d      = regs_q;
    wr_pulse_d  = 1'b0;
    wr_addr_d   = wr_addr_q;
    frame_err_d = 1'b0;
    rd_val      = '0;
    hit         = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (hdr_q[ADDR_W-1:0] == ADDR_W'(i)) begin
        rd_val = regs_q[i*DATA_W +: DATA_W];
        hit    = 1'b1;
      end
    end
    if (state_q == IDLE) begin
      if (armed_q && ncs_fall) begin
        state_d = CMD;
        sh_d    = '0;
        cnt_d   = '0;
        rd_d    = 1'b0;
      end
    end else if (ncs_rise) begin
      state_d = IDLE;
      rd_d    = 1'b0;
      if (cnt_q != CNT_W'(FRAME_W)) frame_err_d = 1'b1;
      else if (hdr_q[ADDR_W] && hit) begin
        for (int i = 0; i < NUM_REGS; i++)
          if (hdr_q[ADDR_W-1:0] == ADDR_W'(i)) regs_d[i*DATA_W +: DATA_W] = sh_q[DATA_W-1:0];
        wr_pulse_d = 1'b1;
        wr_addr_d  = hdr_q[ADDR_W-1:0];
      end
    end else begin
      if (sclk_rise) begin
        sh_d  = SH_W'({sh_q, copi_s});
        cnt_d = cnt_q == CNT_W'(FRAME_W + 1) ? cnt_q : cnt_q + 1'b1;
        if (state_q == CMD && cnt_q == CNT_W'(HDR_W - 1)) begin
          state_d = DATA;
          hdr_d   = {sh_q[ADDR_W-1:0], copi_s};
        end
      end
      if (sclk_fall && state_q == DATA && !hdr_q[ADDR_W]) begin
        rd_d = 1'b1;
        tx_d = rd_q ? tx_q << 1 : rd_val;
      end
    end
  end
  assign cipo      = rd_q & tx_q[DATA_W-1];
  assign cipo_oe   = armed_q && state_q != IDLE && !ncs_s;
  assign regs_flat = regs_q;
  assign wr_pulse  = wr_pulse_q;
  assign wr_addr   = wr_addr_q;
  assign frame_err = frame_err_q;
endmodule

// File: tb/tb_spi_regfile_periph.sv
// tb_spi_regfile_periph: scoreboard bench for the SPI register-file target
module tb_spi_regfile_periph;
  localparam int CLK = 10;
  localparam int HP  = 60;
  logic clk = 0, rst_n = 0, sclk = 0, copi = 0, ncs0 = 1, ncs1 = 1;
  logic cipo0, oe0, wp0, fe0, cipo1, oe1, wp1, fe1;
  logic [39:0] rf0;
  logic [255:0] rf1;
  logic [6:0] wa0;
  logic [3:0] wa1;
  logic [39:0] mdl = '0;
  logic [31:0] rx;
  int n_chk = 0, n_pass = 0, err1_cnt = 0, ma, md, ma1, md1;
  int exp_wa[$], exp_wd[$], exp_err[$], exp_rd[$], exp_wa1[$], exp_wd1[$];
  bit sel = 0;
  always #(CLK/2) clk = ~clk;
  spi_regfile_periph dut0 (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .copi(copi), .ncs(ncs0),
    .cipo(cipo0), .cipo_oe(oe0), .regs_flat(rf0), .wr_pulse(wp0),
    .wr_addr(wa0), .frame_err(fe0)
  );
  spi_regfile_periph #(.NUM_REGS(16), .ADDR_W(4), .DATA_W(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .copi(copi), .ncs(ncs1),
    .cipo(cipo1), .cipo_oe(oe1), .regs_flat(rf1), .wr_pulse(wp1),
    .wr_addr(wa1), .frame_err(fe1)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
  endtask
  // Pop expected commits and errors as the DUTs strobe them
  always @(negedge clk) begin
    if (wp0) begin
      chk("wr_pending", 64'(exp_wa.size() != 0), 1);
      if (exp_wa.size() != 0) begin
        ma = exp_wa.pop_front();
        md = exp_wd.pop_front();
        chk("wr_addr", 64'(wa0), 64'(ma));
        chk("wr_data", 64'(rf0[ma*8 +: 8]), 64'(md));
      end
    end
    if (fe0) begin
      chk("err_pending", 64'(exp_err.size() != 0), 1);
      if (exp_err.size() != 0) void'(exp_err.pop_front());
    end
    if (wp1) begin
      chk("wr1_pending", 64'(exp_wa1.size() != 0), 1);
      if (exp_wa1.size() != 0) begin
        ma1 = exp_wa1.pop_front();
        md1 = exp_wd1.pop_front();
        chk("wr1_addr", 64'(wa1), 64'(ma1));
        chk("wr1_data", 64'(rf1[ma1*16 +: 16]), 64'(md1));
      end
    end
    if (fe1) err1_cnt++;
  end
  task automatic check_reset();
    chk("rst_regs", 64'(rf0), 0);
    chk("rst_cipo", 64'(cipo0), 0);
    chk("rst_oe", 64'(oe0), 0);
    chk("rst_wp", 64'(wp0), 0);
    chk("rst_wa", 64'(wa0), 0);
    chk("rst_fe", 64'(fe0), 0);
    chk("rst_rf1_top", 64'(rf1[255:240]), 0);
  endtask
  task automatic xfer(input int n, input logic [31:0] tx, output logic [31:0] r);
    logic s;
    r = 0;
    if (sel) ncs1 = 0; else ncs0 = 0;
    #HP;
    for (int i = n - 1; i >= 0; i--) begin
      copi = tx[i];
      #HP;
      s = sel ? cipo1 : cipo0;
      r = {r[30:0], s};
      sclk = 1;
      #HP;
      sclk = 0;
    end
    chk("oe_in_frame", 64'(sel ? oe1 : oe0), 1);
    #HP;
    ncs0 = 1;
    ncs1 = 1;
    #(4*HP);
    chk("oe_after_frame", 64'(sel ? oe1 : oe0), 0);
  endtask
  task automatic settle();
    chk("wr_drained", 64'(exp_wa.size()), 0);
    chk("err_drained", 64'(exp_err.size()), 0);
    chk("regs", 64'(rf0), 64'(mdl));
  endtask
  task automatic wr(input int a, input int d);
    if (a < 5) begin
      exp_wa.push_back(a);
      exp_wd.push_back(d);
      mdl[a*8 +: 8] = 8'(d);
    end
    xfer(16, 32'({1'b1, 7'(a), 8'(d)}), rx);
    settle();
  endtask
  task automatic rd(input int a);
    exp_rd.push_back(a < 5 ? int'(mdl[a*8 +: 8]) : 0);
    xfer(16, 32'({1'b0, 7'(a), 8'h00}), rx);
    chk("rd_data", 64'(rx[7:0]), 64'(exp_rd.pop_front()));
    settle();
  endtask
  initial begin
    logic [15:0] f;
    #(3*CLK);
    check_reset();
    rst_n = 1;
    #(10*CLK);
    wr(2, 'hA5);
    rd(2);
    wr('h7F, 'h3C);
    rd('h7F);
    exp_err.push_back(12);
    xfer(12, 32'({1'b1, 7'd4, 8'hFF}) >> 4, rx);
    settle();
    exp_err.push_back(17);
    xfer(17, 32'({1'b1, 7'd4, 8'hFF, 1'b1}), rx);
    settle();
    wr(4, 'h5A);
    rd(4);
    f = {1'b1, 7'd1, 8'h22};
    ncs0 = 0;
    #HP;
    for (int i = 15; i >= 10; i--) begin
      copi = f[i];
      #HP;
      sclk = 1;
      #HP;
      sclk = 0;
    end
    rst_n = 0;
    mdl = '0;
    #(3*CLK);
    check_reset();
    rst_n = 1;
    for (int i = 9; i >= 0; i--) begin
      copi = f[i];
      #HP;
      sclk = 1;
      #HP;
      sclk = 0;
    end
    chk("oe_disarmed", 64'(oe0), 0);
    #HP;
    ncs0 = 1;
    #(4*HP);
    settle();
    wr(1, 'h11);
    rd(1);
    sel = 1;
    exp_wa1.push_back(15);
    exp_wd1.push_back('hBEEF);
    xfer(21, 32'({1'b1, 4'hF, 16'hBEEF}), rx);
    chk("wr1_drained", 64'(exp_wa1.size()), 0);
    chk("rf1_top", 64'(rf1[255:240]), 64'h BEEF);
    chk("rf1_rest_zero", 64'(rf1[239:0] != 0), 0);
    xfer(21, 32'({1'b0, 4'hF, 16'h0000}), rx);
    chk("rd1_data", 64'(rx[15:0]), 64'hBEEF);
    chk("err1_count", 64'(err1_cnt), 0);
    chk("dut0_untouched", 64'(rf0), 64'(mdl));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/spi_regfile_periph.md
Name: spi_regfile_periph

Overview:
Parametrised SPI (mode 0) target that exposes a bank of NUM_REGS configuration registers, each DATA_W bits wide, to an external controller. It is the successor of the write-only SPI config block: it adds register read-back on CIPO, a configurable register count and data width, a commit-on-deassert write model, a write-strobe output and frame-error detection. It sits between the chip pins and the PWM/output-enable logic, all in the clk domain.

Parameters:
NUM_REGS, 5, number of implemented registers (1..2^ADDR_W)
ADDR_W, 7, address field width in the frame
DATA_W, 8, register and data field width
SYNC_STAGES, 2, synchroniser depth for sclk/copi/ncs (>=2)

Ports:
clk  in  1  system clock
rst_n  in  1  reset
sclk  in  1  SPI clock, asynchronous to clk
copi  in  1  controller-out data
ncs  in  1  chip select, active low
cipo  out  1  target-out data
cipo_oe  out  1  pad output enable for cipo
regs_flat  out  NUM_REGS*DATA_W  register contents, reg i at [i*DATA_W +: DATA_W]
wr_pulse  out  1  one-cycle strobe on each committed write
wr_addr  out  ADDR_W  address of the last committed write
frame_err  out  1  one-cycle strobe on each malformed frame

Behaviour:
- Reset: rst_n is asynchronous and active-low; clock is clk. All synchroniser stages for ncs reset to 1, and those for sclk/copi reset to 0. All registers reset to 0, and regs_flat is 0. cipo, cipo_oe, wr_pulse, wr_addr and frame_err are all 0. State is IDLE and disarmed.
- Inputs: sclk, copi and ncs pass through SYNC_STAGES flops. Edges are detected on the last two stages.
- Timing limit: sclk high and low phases must each be at least 4 clk periods. Faster clocks are outside spec.
- Frame format: FRAME_W = 1+ADDR_W+DATA_W bits, sent MSB first. The first bit is R/W (1=write), followed by the address, then the data.
- Arming: after reset the block is disarmed. It arms once synchronised ncs is sampled high. A reset released mid-frame therefore ignores the rest of that frame, with no error.
- States:
  - IDLE: a synchronised ncs falling edge while armed moves to CMD, clearing the shift register and setting bit_cnt=0.
  - CMD: each sclk rising edge shifts in the synchronised copi and increments bit_cnt. When bit_cnt reaches 1+ADDR_W, move to DATA.
  - DATA: rising edges continue shifting. bit_cnt saturates at FRAME_W+1.
- Read path (R/W=0):
  - On the first sclk falling edge after bit_cnt reaches 1+ADDR_W, load the tx shifter with reg[addr], or 0 if addr>=NUM_REGS.
  - cipo = tx MSB; each later falling edge shifts left with zero fill.
  - Outside a read data phase, cipo=0.
- cipo_oe: equals the inverse of synchronised ncs whenever armed and not in IDLE.
- Commit on synchronised ncs rising edge (any state except IDLE, then return to IDLE):
  - bit_cnt==FRAME_W, R/W=1, addr<NUM_REGS: reg[addr]<=data. wr_pulse=1 and wr_addr=addr, visible the cycle after the edge.
  - bit_cnt==FRAME_W, R/W=1, addr>=NUM_REGS: write dropped, no wr_pulse, no error.
  - bit_cnt==FRAME_W, R/W=0: no register change.
  - bit_cnt!=FRAME_W (short or over-long frame): no write, and frame_err=1 for one cycle.
- Simultaneous events: if an ncs rise and an sclk edge are detected in the same cycle, ncs wins and the sclk edge is ignored.
- wr_addr holds its value until the next committed write.
- Ordering: a read issued after a write returns the new value, since the commit completes before any new frame's CMD phase.

Test Plan:
1. Write 0xA5 to reg 2 (frame 1_0000010_10100101), then deassert ncs -> reg2 bits of regs_flat=0xA5, wr_pulse for exactly 1 cycle, wr_addr=2, frame_err=0, other regs 0.
2. After test 1, read reg 2 (frame 0_0000010_xxxxxxxx) -> cipo shifts out 1,0,1,0,0,1,0,1 on bits 9..16, sampled on sclk rising edges; cipo_oe high only while ncs is low; no register change.
3. Write 0x3C to addr 0x7F, then read addr 0x7F -> no wr_pulse, no frame_err, regs_flat unchanged, read returns 0x00.
4. Write to reg 4, deasserting ncs after 12 bits; then a 17-bit write frame -> both frames give one frame_err pulse each and no write (reg4 stays 0). A following valid 16-bit write succeeds.
5. Pulse rst_n low mid-frame after 6 bits, release with ncs still low, finish the frame, then run a new valid write of 0x11 to reg 1 -> no commit from the interrupted frame; reg1=0x11 after the second frame; all outputs were 0 during reset.
6. Parameter sweep NUM_REGS=16, DATA_W=16, ADDR_W=4 -> a 21-bit write of 0xBEEF to reg 15 then read-back returns 0xBEEF; an addr-16 aliasing check is not applicable, so write addr 15 and check regs_flat[255:240]=0xBEEF.
